// File: rtl/magic_glove_pkg.sv
// Shared types and sizes for the glove letter path (word assembler and DTW matcher).
package magic_glove_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_NUM = 15;
  localparam int WORD_W   = CHAR_W * CHAR_NUM;

  // Classifier code for "no gesture"; never stored in a word.
  localparam logic [7:0] CHAR_GAP = 8'h00;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2
  } wa_state_t;

  // Bit offset of letter slot idx inside the packed word.
  function automatic logic [6:0] char_lsb(input logic [3:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/word_assembler_char_debouncer.sv
// Letter debouncer: accepts a letter once it has been seen STABLE_CNT frames in a row,
// and refuses an immediate repeat of the last letter unless a gap frame came between.
module char_debouncer
  import magic_glove_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  output logic       o_accept,
  output logic [7:0] o_letter
);

  localparam logic [3:0] STABLE_Q = STABLE_CNT[3:0];

  logic [7:0] cand_q, cand_d;
  logic [7:0] last_q, last_d;
  logic [3:0] run_q,  run_d;
  logic       gap_q,  gap_d;
  logic       hit_s;
  logic       accept_s;
  logic [7:0] letter_s;

  // Next-state for the run counter, candidate, last letter and gap flag; raises accept.
  always_comb begin
    cand_d   = cand_q;
    last_d   = last_q;
    run_d    = run_q;
    gap_d    = gap_q;
    hit_s    = 1'b0;
    accept_s = 1'b0;
    letter_s = cand_q;
    if (i_clr) begin
      cand_d = CHAR_GAP;
      last_d = CHAR_GAP;
      run_d  = 4'd0;
      gap_d  = 1'b0;
    end else if (i_en && i_valid) begin
      if (i_char == CHAR_GAP) begin
        run_d = 4'd0;
        gap_d = 1'b1;
      end else if (i_char == cand_q) begin
        // Saturate so a held letter reaches the threshold only once.
        if (run_q < STABLE_Q) begin
          run_d = run_q + 4'd1;
          hit_s = ((run_q + 4'd1) == STABLE_Q);
        end else begin
          run_d = run_q;
          hit_s = 1'b0;
        end
      end else begin
        cand_d = i_char;
        run_d  = 4'd1;
        hit_s  = (STABLE_Q == 4'd1);
      end
      if (hit_s && ((cand_d != last_q) || gap_q)) begin
        accept_s = 1'b1;
        letter_s = cand_d;
        last_d   = cand_d;
        gap_d    = 1'b0;
      end else begin
        accept_s = 1'b0;
        letter_s = cand_q;
      end
    end else begin
      hit_s = 1'b0;
    end
  end

  // Debounce state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= CHAR_GAP;
      last_q <= CHAR_GAP;
      run_q  <= 4'd0;
      gap_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      last_q <= last_d;
      run_q  <= run_d;
      gap_q  <= gap_d;
    end
  end

  assign o_accept = accept_s;
  assign o_letter = letter_s;

endmodule

// File: rtl/word_assembler.sv
// Word assembler: packs debounced letters into a 15-char word, detects end of word
// (gesture or idle timeout), pulses start to DTW and holds the word until DTW finishes.
module word_assembler
  import magic_glove_pkg::*;
#(
  parameter int unsigned STABLE_CNT   = 4,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd0
) (
  input  logic          i_WA_clk,
  input  logic          i_WA_rst_n,
  input  logic          i_WA_char_valid,
  input  logic [7:0]    i_WA_char,
  input  logic          i_WA_end,
  input  logic          i_WA_dtw_finish,
  output logic          o_WA_start,
  output logic [119:0]  o_WA_word,
  output logic [3:0]    o_WA_length,
  output logic          o_WA_busy,
  output logic          o_WA_overflow,
  output logic [1:0]    o_state
);

  // Reset input is active-high despite its name.
  logic rst_s;
  assign rst_s = i_WA_rst_n;

  wa_state_t      state_q, state_d;
  logic [119:0]   word_q,  word_d;
  logic [3:0]     length_q, length_d;
  logic           ovf_q,   ovf_d;
  logic [23:0]    tmo_q,   tmo_d;
  logic           start_q, start_d;
  logic           busy_q,  busy_d;

  logic           accept_s;
  logic [7:0]     letter_s;
  logic           clr_s;
  logic           end_s;
  logic           timeout_s;
  logic [23:0]    tmo_next_s;
  logic           collect_s;

  assign collect_s = (state_q == S_COLLECT);

  char_debouncer #(
    .STABLE_CNT (STABLE_CNT)
  ) u_debouncer (
    .clk      (i_WA_clk),
    .rst      (rst_s),
    .i_en     (collect_s),
    .i_clr    (clr_s),
    .i_valid  (i_WA_char_valid),
    .i_char   (i_WA_char),
    .o_accept (accept_s),
    .o_letter (letter_s)
  );

  // FSM next-state, packing, overflow and idle-timeout bookkeeping.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    length_d   = length_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    start_d    = 1'b0;
    clr_s      = 1'b0;
    end_s      = 1'b0;
    timeout_s  = 1'b0;
    tmo_next_s = tmo_q + 24'd1;
    case (state_q)
      S_COLLECT: begin
        // Timeout fires on the cycle the counter would reach IDLE_TIMEOUT, so start
        // rises exactly IDLE_TIMEOUT cycles after the last accept.
        timeout_s = (IDLE_TIMEOUT != 24'd0) && (length_q != 4'd0) && !accept_s &&
                    (tmo_next_s == IDLE_TIMEOUT);
        if (accept_s) begin
          tmo_d = 24'd0;
          if (length_q == 4'd15) begin
            ovf_d = 1'b1;
          end else begin
            word_d[char_lsb(length_q) +: CHAR_W] = letter_s;
            length_d = length_q + 4'd1;
          end
        end else if ((IDLE_TIMEOUT != 24'd0) && (length_q != 4'd0)) begin
          tmo_d = tmo_next_s;
        end else begin
          tmo_d = 24'd0;
        end
        end_s = i_WA_end || timeout_s;
        // An end with nothing collected (even after a same-cycle accept) is ignored.
        if (end_s && (length_d != 4'd0)) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
          tmo_d   = 24'd0;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_WA_dtw_finish) begin
          state_d  = S_COLLECT;
          word_d   = '0;
          length_d = 4'd0;
          ovf_d    = 1'b0;
          tmo_d    = 24'd0;
          clr_s    = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d  = S_COLLECT;
        word_d   = '0;
        length_d = 4'd0;
        ovf_d    = 1'b0;
        tmo_d    = 24'd0;
        clr_s    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_COLLECT);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_WA_clk) begin
    if (rst_s) begin
      state_q  <= S_COLLECT;
      word_q   <= '0;
      length_q <= 4'd0;
      ovf_q    <= 1'b0;
      tmo_q    <= 24'd0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      length_q <= length_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign o_WA_start    = start_q;
  assign o_WA_word     = word_q;
  assign o_WA_length   = length_q;
  assign o_WA_busy     = busy_q;
  assign o_WA_overflow = ovf_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_word_assembler.sv
// Directed self-checking bench for word_assembler (debounce, packing, overflow,
// end/timeout handling, DTW handshake and reset).
module tb_word_assembler;

  logic         clk;
  logic         rst;
  logic         valid0, end0, fin0;
  logic [7:0]   ch0;
  logic         start0, busy0, ovf0;
  logic [119:0] word0;
  logic [3:0]   len0;
  logic [1:0]   st0;
  logic         valid1, end1, fin1;
  logic [7:0]   ch1;
  logic         start1, busy1, ovf1;
  logic [119:0] word1;
  logic [3:0]   len1;
  logic [1:0]   st1;

  int n_total = 0;
  int n_bad   = 0;

  word_assembler #(.STABLE_CNT(4), .IDLE_TIMEOUT(24'd0)) dut0 (
    .i_WA_clk(clk), .i_WA_rst_n(rst), .i_WA_char_valid(valid0), .i_WA_char(ch0),
    .i_WA_end(end0), .i_WA_dtw_finish(fin0), .o_WA_start(start0), .o_WA_word(word0),
    .o_WA_length(len0), .o_WA_busy(busy0), .o_WA_overflow(ovf0), .o_state(st0)
  );

  word_assembler #(.STABLE_CNT(4), .IDLE_TIMEOUT(24'd10)) dut1 (
    .i_WA_clk(clk), .i_WA_rst_n(rst), .i_WA_char_valid(valid1), .i_WA_char(ch1),
    .i_WA_end(end1), .i_WA_dtw_finish(fin1), .o_WA_start(start1), .o_WA_word(word1),
    .o_WA_length(len1), .o_WA_busy(busy1), .o_WA_overflow(ovf1), .o_state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames0(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      valid0 = 1'b1; ch0 = c;
      step();
    end
    valid0 = 1'b0; ch0 = 8'h00;
  endtask

  task automatic frames1(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      valid1 = 1'b1; ch1 = c;
      step();
    end
    valid1 = 1'b0; ch1 = 8'h00;
  endtask

  task automatic pulse_end0();
    end0 = 1'b1; step(); end0 = 1'b0;
  endtask

  task automatic pulse_fin0();
    fin0 = 1'b1; step(); fin0 = 1'b0;
  endtask

  initial begin
    logic [7:0] c;
    int cyc;
    rst = 1'b1;
    valid0 = 1'b0; ch0 = 8'h00; end0 = 1'b0; fin0 = 1'b0;
    valid1 = 1'b0; ch1 = 8'h00; end1 = 1'b0; fin1 = 1'b0;
    step(); step();
    check("rst_start", 120'(start0), 120'd0);
    check("rst_word",  word0, 120'd0);
    check("rst_len",   120'(len0), 120'd0);
    check("rst_busy",  120'(busy0), 120'd0);
    check("rst_ovf",   120'(ovf0), 120'd0);
    check("rst_state", 120'(st0), 120'd0);
    rst = 1'b0;
    step();

    // 1: "hi" with a gap between letters, end -> start next cycle
    frames0(8'h68, 4);
    frames0(8'h00, 1);
    frames0(8'h69, 4);
    check("t1_len_pre", 120'(len0), 120'd2);
    check("t1_start_pre", 120'(start0), 120'd0);
    pulse_end0();
    check("t1_start", 120'(start0), 120'd1);
    check("t1_state_issue", 120'(st0), 120'd1);
    check("t1_busy", 120'(busy0), 120'd1);
    step();
    check("t1_start_once", 120'(start0), 120'd0);
    check("t1_state_wait", 120'(st0), 120'd2);
    check("t1_word", word0, 120'h6968);
    check("t1_len", 120'(len0), 120'd2);
    pulse_fin0();
    check("t1_fin_state", 120'(st0), 120'd0);
    check("t1_fin_word", word0, 120'd0);
    check("t1_fin_len", 120'(len0), 120'd0);

    // 2: repeat after gap accepted, held letter not doubled
    frames0(8'h6c, 4);
    frames0(8'h00, 3);
    frames0(8'h6c, 4);
    check("t2_ll_len", 120'(len0), 120'd2);
    check("t2_ll_word", word0, 120'h6c6c);
    pulse_end0(); step(); pulse_fin0();
    frames0(8'h6c, 9);
    check("t2_held_len", 120'(len0), 120'd1);
    check("t2_held_word", word0, 120'h6c);
    pulse_end0(); step(); pulse_fin0();

    // 3: 16 distinct letters -> overflow
    for (int k = 0; k < 16; k++) begin
      c = 8'h61 + 8'(k);
      frames0(c, 4);
    end
    check("t3_len", 120'(len0), 120'd15);
    check("t3_ovf", 120'(ovf0), 120'd1);
    check("t3_top", 120'(word0[119:112]), 120'h6f);
    check("t3_bottom", 120'(word0[7:0]), 120'h61);
    pulse_end0(); step();
    check("t3_ovf_wait", 120'(ovf0), 120'd1);
    pulse_fin0();
    check("t3_ovf_clr", 120'(ovf0), 120'd0);
    check("t3_word_clr", word0, 120'd0);

    // 4: empty end ignored; end coinciding with 4th frame includes the letter
    pulse_end0();
    check("t4_empty_start", 120'(start0), 120'd0);
    check("t4_empty_state", 120'(st0), 120'd0);
    step();
    check("t4_empty_start2", 120'(start0), 120'd0);
    frames0(8'h71, 3);
    valid0 = 1'b1; ch0 = 8'h71; end0 = 1'b1;
    step();
    valid0 = 1'b0; ch0 = 8'h00; end0 = 1'b0;
    check("t4_same_start", 120'(start0), 120'd1);
    step();
    check("t4_same_len", 120'(len0), 120'd1);
    check("t4_same_word", word0, 120'h71);
    pulse_fin0();

    // 5: idle timeout of 10 cycles on the second instance
    frames1(8'h7a, 4);
    check("t5_len", 120'(len1), 120'd1);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!start1 && cyc < 40);
    check("t5_latency", 120'(cyc), 120'd10);
    step();
    check("t5_state_wait", 120'(st1), 120'd2);
    frames1(8'h79, 4);
    check("t5_word_frozen", word1, 120'h7a);
    check("t5_len_frozen", 120'(len1), 120'd1);
    fin1 = 1'b1; step(); fin1 = 1'b0;
    check("t5_fin_state", 120'(st1), 120'd0);
    check("t5_fin_word", word1, 120'd0);

    // 6: reset while waiting for DTW
    frames0(8'h61, 4);
    pulse_end0(); step();
    check("t6_wait", 120'(st0), 120'd2);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_start", 120'(start0), 120'd0);
    check("t6_word", word0, 120'd0);
    check("t6_len", 120'(len0), 120'd0);
    check("t6_busy", 120'(busy0), 120'd0);
    check("t6_ovf", 120'(ovf0), 120'd0);
    check("t6_state", 120'(st0), 120'd0);
    step();
    check("t6_start2", 120'(start0), 120'd0);
    check("t6_state2", 120'(st0), 120'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
